// File: rtl/scalar_bit_sequencer_if.sv
// Command channel from the bit sequencer to the point-arithmetic unit.
// The master drives op_valid, op_code and op_idx; the slave answers with op_ready.
interface scalar_bit_sequencer_if #(
  parameter int IW = 8
);
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic [IW-1:0] op_idx;

  modport master (
    output op_valid,
    output op_code,
    output op_idx,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_idx,
    output op_ready
  );
endinterface

// File: rtl/scalar_bit_sequencer.sv
// Walks a scalar MSB-first from the encoder's top-set-bit index and issues
// left-to-right double-and-add commands (INIT, DBL, ADD) to the point unit.
module scalar_bit_sequencer #(
  parameter int N  = 255,
  parameter int IW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N-1:0]           scalar,
  input  logic [IW-1:0]          top_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   zero,
  output logic                   err,
  scalar_bit_sequencer_if.master ops
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_EVAL,
    S_INIT,
    S_DBL,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [1:0]    OP_INIT = 2'b00;
  localparam logic [1:0]    OP_DBL  = 2'b01;
  localparam logic [1:0]    OP_ADD  = 2'b10;
  localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

  state_t             state;
  logic [N-1:0]       sr;
  logic [IW-1:0]      ix;
  logic               chk_err;
  logic               chk_bit;
  logic [2**IW-1:0]   sr_ext;
  logic               sel_bit;
  logic               hs;

  // Widen the captured scalar to the full index range so an out-of-range
  // index selects a defined 0 instead of falling off the end of the vector.
  always_comb begin
    sr_ext         = '0;
    sr_ext[N-1:0]  = sr;
  end

  assign sel_bit = sr_ext[ix];
  assign hs      = ops.op_valid && ops.op_ready;

  // The check runs in two registered steps: the range test and the bit
  // select are sampled first, then acted on, so the wide mux never feeds
  // the command outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      sr           <= '0;
      ix           <= '0;
      chk_err      <= 1'b0;
      chk_bit      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      zero         <= 1'b0;
      err          <= 1'b0;
      ops.op_valid <= 1'b0;
      ops.op_code  <= OP_INIT;
      ops.op_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          zero <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            sr    <= scalar;
            ix    <= top_idx;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          chk_err <= (ix > MAX_IDX);
          chk_bit <= sel_bit;
          state   <= S_EVAL;
        end

        S_EVAL: begin
          if (chk_err) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (!chk_bit) begin
            zero  <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            ops.op_valid <= 1'b1;
            ops.op_code  <= OP_INIT;
            ops.op_idx   <= ix;
            state        <= S_INIT;
          end
        end

        // INIT and ADD both close out a bit: either the scan ends at bit 0
        // or the next lower bit starts with a doubling.
        S_INIT, S_ADD: begin
          if (hs) begin
            if (ix == '0) begin
              ops.op_valid <= 1'b0;
              ops.op_code  <= OP_INIT;
              ops.op_idx   <= '0;
              done         <= 1'b1;
              state        <= S_DONE;
            end else begin
              ix          <= ix - 1'b1;
              ops.op_code <= OP_DBL;
              ops.op_idx  <= ix - 1'b1;
              state       <= S_DBL;
            end
          end
        end

        S_DBL: begin
          if (hs) begin
            if (sel_bit) begin
              ops.op_code <= OP_ADD;
              state       <= S_ADD;
            end else if (ix == '0) begin
              ops.op_valid <= 1'b0;
              ops.op_code  <= OP_INIT;
              ops.op_idx   <= '0;
              done         <= 1'b1;
              state        <= S_DONE;
            end else begin
              ix         <= ix - 1'b1;
              ops.op_idx <= ix - 1'b1;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          zero  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_bit_sequencer.sv
// Randomised self-checking bench: every scan is compared against a command
// list derived directly from the double-and-add rules.
module tb_scalar_bit_sequencer;

  localparam int N  = 255;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  scalar;
  logic [IW-1:0] top_idx;
  logic          busy;
  logic          done;
  logic          zero;
  logic          err;

  scalar_bit_sequencer_if #(.IW(IW)) ops_if ();

  scalar_bit_sequencer #(.N(N), .IW(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .scalar  (scalar),
    .top_idx (top_idx),
    .busy    (busy),
    .done    (done),
    .zero    (zero),
    .err     (err),
    .ops     (ops_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         obs_cyc[$];
  bit         exp_err;
  bit         exp_zero;

  int done_cyc;
  int done_cnt;
  bit got_zero;
  bit got_err;
  int busy_cnt;
  int stab_bad;
  int idle_bad;
  int stalls;
  bit timeout;

  // Reference: INIT for the top bit, then for each lower bit a DBL followed
  // by an ADD when that bit is set.
  task automatic build_model(input logic [N-1:0] s, input logic [7:0] t);
    exp_q.delete();
    exp_err  = 1'b0;
    exp_zero = 1'b0;
    if (int'(t) > N - 1) begin
      exp_err = 1'b1;
    end else if (!s[t]) begin
      exp_zero = 1'b1;
    end else begin
      exp_q.push_back({2'b00, t});
      for (int i = int'(t) - 1; i >= 0; i--) begin
        exp_q.push_back({2'b01, 8'(i)});
        if (s[i]) exp_q.push_back({2'b10, 8'(i)});
      end
    end
  endtask

  // rmode: 0 always ready, 1 random ready, 2 stall three cycles on DBL index 2.
  // Cycle 0 is the sample right after the edge that accepts start.
  task automatic do_scan(input logic [N-1:0] s, input logic [7:0] t, input int rmode);
    int         stall_left;
    bit         prev_hold;
    logic [9:0] prev_op;
    bit         finished;
    bit         rdy;
    obs_q.delete();
    obs_cyc.delete();
    done_cyc = -1; done_cnt = 0; got_zero = 0; got_err = 0; busy_cnt = 0;
    stab_bad = 0; idle_bad = 0; stalls = 0; timeout = 0;
    @(negedge clk);
    start = 1'b1; scalar = s; top_idx = t; ops_if.op_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    stall_left = 3; prev_hold = 0; prev_op = '0; finished = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (rmode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: begin
          rdy = 1'b1;
          if (ops_if.op_valid && ops_if.op_code == 2'b01 && ops_if.op_idx == 8'd2 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end
        end
        default: rdy = 1'b1;
      endcase
      ops_if.op_ready = rdy;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; got_zero = zero; got_err = err;
        end
      end
      if (ops_if.op_code == 2'b11) idle_bad++;
      if (prev_hold && !(ops_if.op_valid && {ops_if.op_code, ops_if.op_idx} == prev_op)) stab_bad++;
      if (ops_if.op_valid) begin
        if (rdy) begin
          obs_q.push_back({ops_if.op_code, ops_if.op_idx});
          obs_cyc.push_back(cyc);
        end else begin
          stalls++;
        end
        prev_hold = !rdy;
        prev_op   = {ops_if.op_code, ops_if.op_idx};
      end else begin
        prev_hold = 0;
        if (ops_if.op_idx != '0) idle_bad++;
      end
      if (!busy && done_cyc >= 0) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    ops_if.op_ready = 1'b0;
    if (!finished) begin
      timeout = 1;
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; scalar = '0; top_idx = '0; ops_if.op_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, zero, err, ops_if.op_valid, ops_if.op_code, ops_if.op_idx} !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {busy, done, zero, err, ops_if.op_valid, ops_if.op_code, ops_if.op_idx});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, ops_if.op_valid} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got busy/done/valid %b expected 000", {busy, done, ops_if.op_valid});
    end
  endtask

  task automatic test_zero_scalar;
    do_scan('0, 8'd0, 0);
    n_checks++;
    if (timeout) begin n_fail++; $display("[TB] FAIL zero_timeout: got no done, expected done"); end
    n_checks++;
    if ({got_zero, got_err} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL zero_flags: got zero/err %b expected 10", {got_zero, got_err});
    end
    n_checks++;
    if (obs_q.size() != 0 || stalls != 0) begin
      n_fail++; $display("[TB] FAIL zero_no_ops: got %0d ops presented, expected 0", obs_q.size() + stalls);
    end
    n_checks++;
    if (done_cyc != 2 || done_cnt != 1) begin
      n_fail++; $display("[TB] FAIL zero_done_timing: got cycle %0d count %0d, expected cycle 2 count 1", done_cyc, done_cnt);
    end
    n_checks++;
    if (busy_cnt != 3) begin
      n_fail++; $display("[TB] FAIL zero_busy_len: got %0d cycles, expected 3", busy_cnt);
    end
  endtask

  task automatic test_single_bit;
    do_scan(N'(1), 8'd0, 0);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("[TB] FAIL single_count: got %0d ops, expected 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== 10'h000) begin
        n_fail++; $display("[TB] FAIL single_op: got %h expected 000", obs_q[0]);
      end
    end
    n_checks++;
    if ({got_zero, got_err} !== 2'b00 || done_cyc != 3) begin
      n_fail++; $display("[TB] FAIL single_done: got flags %b cycle %0d, expected 00 cycle 3", {got_zero, got_err}, done_cyc);
    end
  endtask

  task automatic test_pattern_b;
    int bad;
    build_model(N'(11), 8'd3);
    do_scan(N'(11), 8'd3, 0);
    n_checks++;
    if (obs_q.size() != 6 || exp_q.size() != 6) begin
      n_fail++; $display("[TB] FAIL b_count: got %0d ops, expected 6", obs_q.size());
    end
    n_checks++;
    bad = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
    if (bad >= 0) begin
      n_fail++; $display("[TB] FAIL b_sequence: op %0d got %h expected %h", bad, obs_q[bad], exp_q[bad]);
    end
    n_checks++;
    bad = -1;
    for (int i = 0; i < obs_cyc.size(); i++)
      if (obs_cyc[i] != 2 + i && bad < 0) bad = i;
    if (bad >= 0) begin
      n_fail++; $display("[TB] FAIL b_throughput: op %0d got cycle %0d expected %0d", bad, obs_cyc[bad], 2 + bad);
    end
    n_checks++;
    if (done_cyc != 8 || done_cnt != 1) begin
      n_fail++; $display("[TB] FAIL b_done: got cycle %0d count %0d, expected cycle 8 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    build_model(N'(11), 8'd3);
    do_scan(N'(11), 8'd3, 2);
    n_checks++;
    if (stalls != 3 || stab_bad != 0) begin
      n_fail++; $display("[TB] FAIL bp_hold: got stalls %0d unstable %0d, expected 3 and 0", stalls, stab_bad);
    end
    n_checks++;
    bad = (obs_q.size() != exp_q.size()) ? obs_q.size() : -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
    if (bad >= 0) begin
      n_fail++; $display("[TB] FAIL bp_sequence: first difference at op %0d of %0d, expected %0d ops", bad, obs_q.size(), exp_q.size());
    end
    n_checks++;
    if (done_cyc != 11) begin
      n_fail++; $display("[TB] FAIL bp_done: got cycle %0d expected 11", done_cyc);
    end
  endtask

  task automatic test_long_and_err;
    logic [N-1:0] s;
    int bad;
    s = '0;
    s[N-1] = 1'b1;
    build_model(s, 8'd254);
    do_scan(s, 8'd254, 0);
    n_checks++;
    if (obs_q.size() != 255 || done_cyc != 257) begin
      n_fail++; $display("[TB] FAIL long_count: got %0d ops done cycle %0d, expected 255 and 257", obs_q.size(), done_cyc);
    end
    n_checks++;
    bad = (obs_q.size() != exp_q.size()) ? obs_q.size() : -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
    if (bad >= 0) begin
      n_fail++; $display("[TB] FAIL long_sequence: first difference at op %0d of %0d", bad, obs_q.size());
    end
    do_scan(s, 8'd255, 0);
    n_checks++;
    if ({got_zero, got_err} !== 2'b01 || obs_q.size() != 0 || stalls != 0 || done_cyc != 2) begin
      n_fail++; $display("[TB] FAIL err_index: got flags %b ops %0d cycle %0d, expected 01 0 2",
                         {got_zero, got_err}, obs_q.size() + stalls, done_cyc);
    end
  endtask

  task automatic test_reset_midscan;
    logic [N-1:0] s;
    int bad;
    s = '0;
    s[N-1] = 1'b1;
    s[0] = 1'b1;
    @(negedge clk);
    start = 1'b1; scalar = s; top_idx = 8'd254; ops_if.op_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (ops_if.op_valid !== 1'b1 || ops_if.op_code !== 2'b01) begin
      n_fail++; $display("[TB] FAIL mid_active: got valid %b code %b, expected 1 01", ops_if.op_valid, ops_if.op_code);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, zero, err, ops_if.op_valid, ops_if.op_code, ops_if.op_idx} !== 15'd0) begin
      n_fail++; $display("[TB] FAIL mid_async_reset: got %b expected all zero",
                         {busy, done, zero, err, ops_if.op_valid, ops_if.op_code, ops_if.op_idx});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || ops_if.op_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("[TB] FAIL mid_silent: got %0d active cycles after reset, expected 0", bad);
    end
    build_model(N'(11), 8'd3);
    do_scan(N'(11), 8'd3, 0);
    n_checks++;
    bad = (obs_q.size() != exp_q.size()) ? obs_q.size() : -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
    if (bad >= 0 || done_cyc != 8) begin
      n_fail++; $display("[TB] FAIL mid_restart: got diff at %0d done cycle %0d, expected none and 8", bad, done_cyc);
    end
  endtask

  task automatic test_random;
    logic [255:0] raw;
    logic [N-1:0] s;
    logic [7:0]   t;
    int           w;
    int           bad;
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 8; j++) raw[j*32 +: 32] = $urandom;
      s = raw[N-1:0];
      w = $urandom_range(1, N);
      for (int b = w; b < N; b++) s[b] = 1'b0;
      t = '0;
      for (int b = 0; b < N; b++) if (s[b]) t = 8'(b);
      if ($urandom_range(0, 4) == 0) t = 8'($urandom_range(0, 255));
      build_model(s, t);
      do_scan(s, t, 1);
      n_checks++;
      if (timeout || done_cnt != 1) begin
        n_fail++; $display("[TB] FAIL rnd%0d_done: got timeout %0d done count %0d, expected 0 and 1", it, timeout, done_cnt);
      end
      n_checks++;
      if ({got_zero, got_err} !== {exp_zero, exp_err}) begin
        n_fail++; $display("[TB] FAIL rnd%0d_flags: got zero/err %b expected %b", it, {got_zero, got_err}, {exp_zero, exp_err});
      end
      n_checks++;
      bad = (obs_q.size() != exp_q.size()) ? obs_q.size() : -1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
        if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (bad >= 0) begin
        n_fail++; $display("[TB] FAIL rnd%0d_sequence: first difference at op %0d, got %0d ops expected %0d", it, bad, obs_q.size(), exp_q.size());
      end
      n_checks++;
      if (stab_bad != 0 || idle_bad != 0 || done_cyc != 2 + obs_q.size() + stalls) begin
        n_fail++; $display("[TB] FAIL rnd%0d_timing: got unstable %0d idle %0d done cycle %0d, expected 0 0 %0d",
                           it, stab_bad, idle_bad, done_cyc, 2 + obs_q.size() + stalls);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_zero_scalar();
    test_single_bit();
    test_pattern_b();
    test_backpressure();
    test_long_and_err();
    test_reset_midscan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_bit_sequencer.md
Name: scalar_bit_sequencer

Overview:
- Consumes the 8-bit top-set-bit index produced by the 255-bit priority encoder, together with the 255-bit scalar it was computed from.
- Walks the scalar MSB-first from that index down to bit 0.
- Emits a stream of left-to-right double-and-add commands (INIT, DBL, ADD) over a valid/ready handshake to the point-arithmetic unit.
- Reports completion and flags zero scalars and out-of-range indices.

Parameters:
- N, 255: scalar width in bits.
- IW, $clog2(N) (= 8): index width; matches the encoder output width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a scan; sampled only in IDLE
- scalar  in  N  scalar value, captured on accepted start
- top_idx  in  IW  highest set bit index from encoder, captured on accepted start
- busy  out  1  high from accepted start until done pulse inclusive
- op_valid  out  1  command valid
- op_ready  in  1  consumer accepts command when op_valid && op_ready
- op_code  out  2  00 INIT (acc = P), 01 DBL (acc = 2·acc), 10 ADD (acc = acc + P); 11 never driven
- op_idx  out  IW  scalar bit index the command belongs to
- done  out  1  one-cycle completion pulse
- zero  out  1  valid with done: scalar was zero, no commands issued
- err  out  1  valid with done: top_idx > N-1, no commands issued

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0 (busy, op_valid, op_code, op_idx, done, zero, err); internal scalar and index registers 0. Reset mid-scan abandons the scan silently: no done pulse, no further ops.
- States:
  - IDLE: start=1 latches scalar→sr and top_idx→ix, sets busy=1, goes to CHECK. start while busy is ignored (never queued).
  - CHECK (1 cycle, no op):
    - ix > N-1 → DONE with err=1.
    - else sr[ix]==0 → DONE with zero=1. This covers scalar==0 (encoder returns 0), and any index inconsistent with the scalar is also reported zero.
    - else → INIT.
  - INIT: op_valid=1, op_code=00, op_idx=ix. On handshake: if ix==0 → DONE; else ix←ix-1 → DBL.
  - DBL: op_valid=1, op_code=01, op_idx=ix. On handshake: sr[ix]==1 → ADD; else if ix==0 → DONE; else ix←ix-1, stay in DBL.
  - ADD: op_valid=1, op_code=10, op_idx=ix. On handshake: ix==0 → DONE; else ix←ix-1 → DBL.
  - DONE (1 cycle): done=1, busy=1, zero/err as set in CHECK (0 otherwise) → IDLE. zero/err clear in IDLE.
- Handshake:
  - op_valid, op_code and op_idx are registered outputs and stay stable while op_valid && !op_ready.
  - op_valid never drops without a handshake except on reset.
  - op_ready has no effect when op_valid=0.
  - Full throughput: one command per cycle while op_ready=1.
- Latency:
  - Accepted start at edge k → CHECK at k+1 → first op_valid (or done) visible after edge k+2.
  - Done asserts the cycle after the final handshake.
- Command count for top index t with popcount p: 1 + t + (p-1) = t + p. ix never underflows; decrement happens only when ix>0.
- op_idx always carries the bit index of the command; it is 0 outside INIT/DBL/ADD.

Test Plan:
- scalar=0, top_idx=0, op_ready=1 → no op_valid ever; done=1 with zero=1, err=0 in the 2nd cycle after start; busy high 3 cycles.
- scalar=1, top_idx=0 → single INIT(idx 0), then done with zero=0; exactly 1 handshake.
- scalar=0xB, top_idx=3, op_ready=1 → INIT3, DBL2, DBL1, ADD1, DBL0, ADD0 on consecutive cycles; done next cycle; 6 ops total.
- scalar=0xB with op_ready low for 3 cycles while DBL2 is presented → op_code=01, op_idx=2 held stable; sequence otherwise identical to the previous case.
- scalar=1<<254, top_idx=254 → INIT254 then DBL253..DBL0, no ADD; 255 handshakes; top_idx=255 instead → done with err=1, no ops.
- rst asserted during DBL of a long scan → all outputs 0 immediately (async); no done pulse; a new start after reset release runs normally.
